// File: rtl/trng_word_sched.sv
// Purpose : round-robin arbiter that gathers WORD_W valid TRNG bits per granted request and returns the word.
// Latency : request-to-ack WORD_W+1 cycles with trng_valid every cycle; acks at least WORD_W+2 cycles apart.
// Backpres: requesters hold req until ack; the TRNG core paces the word via trng_valid, bounded by TIMEOUT.
//
// Ports:
//   clk, reset            sole rising-edge clock, synchronous active-high reset
//   req[NREQ-1:0]         level requests, held until the matching ack bit
//   ack[NREQ-1:0]         one-hot, one-cycle delivery pulse
//   rdata[WORD_W-1:0]     collected word, valid with ack, held until the next delivery
//   err                   qualifies ack: timeout, rdata forced to zero
//   trng_req              high while collecting bits
//   trng_bit, trng_valid  bit stream from the TRNG core
module trng_word_sched #(
    parameter int NREQ    = 2,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err,
    output logic              trng_req,
    input  logic              trng_bit,
    input  logic              trng_valid
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(WORD_W);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       last_grant_q;
    logic [WORD_W-1:0]   shreg;
    logic [BW-1:0]       bit_cnt;
    logic [TW-1:0]       tmo_cnt;
    logic [WORD_W-1:0]   rdata_q;
    logic                err_q;

    // Control strobes produced by the next-state logic
    logic                take_grant;
    logic                shift_en;
    logic                tick;
    logic                finish_ok;
    logic                finish_err;

    // Round-robin pick
    logic                pick_vld;
    logic [GW-1:0]       pick_idx;
    logic [GW-1:0]       cand;

    logic [WORD_W-1:0]   word_out;

    // Walk upward from last_grant+1, wrapping at NREQ-1, and take the first
    // pending request. Works for non-power-of-two NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = last_grant_q;
        for (int i = 0; i < NREQ; i++) begin
            cand = (cand == GW'(NREQ - 1)) ? '0 : cand + GW'(1);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        take_grant = 1'b0;
        shift_en   = 1'b0;
        tick       = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    take_grant = 1'b1;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                // A withdrawn request wins over both the final bit and the timeout.
                if (!req[grant_q]) begin
                    state_d = IDLE;
                end else if (trng_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BW'(WORD_W - 1)) begin
                        finish_ok = 1'b1;
                        state_d   = DONE;
                    end
                end else begin
                    tick = 1'b1;
                    // Counter restarts at 0 the cycle after a valid bit, so
                    // firing on TIMEOUT-2 lands DONE exactly TIMEOUT cycles later.
                    if (tmo_cnt == TW'(TIMEOUT - 2)) begin
                        finish_err = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            shreg        <= '0;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (take_grant) begin
                grant_q <= pick_idx;
                shreg   <= '0;
                bit_cnt <= '0;
                tmo_cnt <= '0;
            end

            if (shift_en) begin
                shreg   <= {shreg[WORD_W-2:0], trng_bit};
                bit_cnt <= bit_cnt + BW'(1);
                tmo_cnt <= '0;
            end else if (tick && (tmo_cnt != TW'(TIMEOUT - 1))) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end

            // err is a pulse aligned with ack: set on DONE entry, dropped on exit.
            if (finish_ok || finish_err) begin
                err_q <= finish_err;
            end else if (state_q == DONE) begin
                err_q <= 1'b0;
            end

            if (state_q == DONE) begin
                rdata_q      <= word_out;
                last_grant_q <= grant_q;
            end
        end
    end

    // In DONE the shift register already holds the full word; the holding
    // register takes it at the end of DONE so rdata stays stable afterwards.
    assign word_out = err_q ? '0 : shreg;
    assign rdata    = (state_q == DONE) ? word_out : rdata_q;
    assign err      = err_q;
    assign trng_req = (state_q == COLLECT);

    always_comb begin
        ack = '0;
        if (state_q == DONE) begin
            ack[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_trng_word_sched.sv
// Purpose : directed, table-driven check of trng_word_sched (NREQ=2, WORD_W=32, TIMEOUT=8).
// Latency : inputs driven 1 time unit after each rising edge, outputs read at the same point.
// Backpres: not applicable; fixed cycle schedules, no open-ended waits.
module tb_trng_word_sched;

    localparam int NREQ    = 2;
    localparam int WORD_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   ack;
    logic [WORD_W-1:0] rdata;
    logic              err;
    logic              trng_req;
    logic              trng_bit;
    logic              trng_valid;

    int n_vec;
    int n_bad;

    trng_word_sched #(
        .NREQ    (NREQ),
        .WORD_W  (WORD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ack        (ack),
        .rdata      (rdata),
        .err        (err),
        .trng_req   (trng_req),
        .trng_bit   (trng_bit),
        .trng_valid (trng_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              stray;
        logic [NREQ-1:0]   req;
        logic [WORD_W-1:0] word;
        logic [NREQ-1:0]   exp_ack;
        logic [WORD_W-1:0] exp_rdata;
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Leaves the bench in a cycle where reset is low and the DUT is IDLE.
    task automatic do_reset();
        reset      = 1'b1;
        req        = '0;
        trng_valid = 1'b0;
        trng_bit   = 1'b0;
        step();
        step();
        chk("rst_ack",      ack,      64'h0);
        chk("rst_err",      err,      64'h0);
        chk("rst_rdata",    rdata,    64'h0);
        chk("rst_trng_req", trng_req, 64'h0);
        reset = 1'b0;
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after the ack.
    task automatic run_word(input logic [NREQ-1:0] r, input logic [WORD_W-1:0] w,
                            input logic [NREQ-1:0] eack, input logic [WORD_W-1:0] erd,
                            input logic stray);
        req        = r;
        trng_valid = stray;
        trng_bit   = 1'b1;
        step();
        for (int k = 0; k < WORD_W; k++) begin
            chk("collect_trng_req", trng_req, 64'h1);
            chk("collect_no_ack",   ack,      64'h0);
            trng_valid = 1'b1;
            trng_bit   = w[WORD_W-1-k];
            step();
        end
        chk("word_ack",      ack,      64'(eack));
        chk("word_rdata",    rdata,    64'(erd));
        chk("word_err",      err,      64'h0);
        chk("word_trng_req", trng_req, 64'h0);
        trng_valid = stray;
        trng_bit   = 1'b1;
        step();
        chk("rdata_held",    rdata,    64'(erd));
        chk("ack_one_cycle", ack,      64'h0);
        trng_valid = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        req        = '0;
        trng_bit   = 1'b0;
        trng_valid = 1'b0;

        //            rst   stray req    word           exp_ack exp_rdata
        tbl[0] = '{1'b1, 1'b0, 2'b01, 32'hA5A5_0F0F, 2'b01, 32'hA5A5_0F0F};
        tbl[1] = '{1'b1, 1'b0, 2'b11, 32'h1234_5678, 2'b01, 32'h1234_5678};
        tbl[2] = '{1'b0, 1'b0, 2'b11, 32'h9ABC_DEF0, 2'b10, 32'h9ABC_DEF0};
        tbl[3] = '{1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFF};
        tbl[4] = '{1'b0, 1'b1, 2'b11, 32'h0000_0000, 2'b10, 32'h0000_0000};
        tbl[5] = '{1'b0, 1'b0, 2'b10, 32'h8000_0001, 2'b10, 32'h8000_0001};
        tbl[6] = '{1'b0, 1'b1, 2'b01, 32'h7FFF_FFFE, 2'b01, 32'h7FFF_FFFE};

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].rst) do_reset();
            run_word(tbl[i].req, tbl[i].word, tbl[i].exp_ack, tbl[i].exp_rdata, tbl[i].stray);
        end

        // Timeout: five valid bits, then silence; error ack 8 cycles after the 5th.
        do_reset();
        req        = 2'b01;
        trng_valid = 1'b0;
        step();
        for (int k = 1; k <= 5; k++) begin
            chk("tmo_trng_req", trng_req, 64'h1);
            trng_valid = 1'b1;
            trng_bit   = k[0];
            step();
        end
        trng_valid = 1'b0;
        for (int k = 6; k <= 12; k++) begin
            chk("tmo_wait_trng_req", trng_req, 64'h1);
            chk("tmo_wait_no_ack",   ack,      64'h0);
            step();
        end
        chk("tmo_ack",   ack,   64'h1);
        chk("tmo_err",   err,   64'h1);
        chk("tmo_rdata", rdata, 64'h0);
        step();
        chk("tmo_err_pulse", err,   64'h0);
        chk("tmo_rdata_hold", rdata, 64'h0);
        run_word(2'b01, 32'h3C3C_00FF, 2'b01, 32'h3C3C_00FF, 1'b0);

        // Abort: requester 0 drops after 10 bits while requester 1 waits.
        do_reset();
        req        = 2'b11;
        trng_valid = 1'b0;
        step();
        for (int k = 1; k <= 10; k++) begin
            chk("abort_trng_req", trng_req, 64'h1);
            trng_valid = 1'b1;
            trng_bit   = 1'b1;
            step();
        end
        req = 2'b10;
        chk("abort_last_collect", trng_req, 64'h1);
        step();
        chk("abort_idle_trng_req", trng_req, 64'h0);
        chk("abort_no_ack",        ack,      64'h0);
        trng_valid = 1'b0;
        run_word(2'b10, 32'h5555_AAAA, 2'b10, 32'h5555_AAAA, 1'b0);

        // Reset during collection at bit 16.
        req        = 2'b01;
        trng_valid = 1'b0;
        step();
        for (int k = 1; k <= 16; k++) begin
            chk("rstmid_trng_req", trng_req, 64'h1);
            trng_valid = 1'b1;
            trng_bit   = 1'b0;
            step();
        end
        reset = 1'b1;
        step();
        chk("rstmid_trng_req_low", trng_req, 64'h0);
        chk("rstmid_ack",          ack,      64'h0);
        chk("rstmid_err",          err,      64'h0);
        chk("rstmid_rdata",        rdata,    64'h0);
        reset      = 1'b0;
        trng_valid = 1'b0;
        run_word(2'b01, 32'hC001_D00D, 2'b01, 32'hC001_D00D, 1'b0);

        // Stray valid pulses with nobody requesting.
        req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            trng_valid = 1'b1;
            trng_bit   = 1'b1;
            step();
            chk("stray_idle_trng_req", trng_req, 64'h0);
            chk("stray_idle_ack",      ack,      64'h0);
        end
        run_word(2'b01, 32'h0000_0000, 2'b01, 32'h0000_0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
